// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, timeout default, sequencer state
// and owner encoding for the memory port arbiter.
package mem_arbiter_pkg;

    localparam int PADDR       = 18;
    localparam int WORD        = 36;
    localparam int MEM_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port of the memory arbiter.
// master = requester (CPU or DMA), slave = arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic             req;
    logic             write;
    logic [PADDR-1:0] addr;
    logic [WORD-1:0]  wdata;
    logic [WORD-1:0]  rdata;
    logic             ack;
    logic             nxm;

    modport master (
        output req, write, addr, wdata,
        input  rdata, ack, nxm
    );

    modport slave (
        input  req, write, addr, wdata,
        output rdata, ack, nxm
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
// grant is the winning port index; on contention the port not in last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // Choose a winner among the active requests
    always_comb begin
        grant = 1'b0;
        valid = |req;
        unique case (1'b1)
            (req == 2'b11): grant = ~last;
            (req == 2'b10): grant = 1'b1;
            default:        grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between CPU and DMA, issuing one-cycle
// strobes, returning data/ack to the winner and flagging NXM on timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.slave     cpu,
    mem_arbiter_if.slave     dma,
    output logic [PADDR-1:0] mem_addr,
    output logic [WORD-1:0]  mem_write_data,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [WORD-1:0]  mem_read_data,
    input  logic             read_ack,
    input  logic             write_ack
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX = 8'hFF;

    state_t           r_state, w_state;
    owner_t           r_owner, w_owner;
    logic             r_last, w_last;
    logic             r_write, w_write;
    logic [PADDR-1:0] r_addr, w_addr;
    logic [WORD-1:0]  r_wdata, w_wdata;
    logic [7:0]       r_cnt, w_cnt;
    logic             r_mem_read, w_mem_read;
    logic             r_mem_write, w_mem_write;
    logic             r_cpu_ack, w_cpu_ack;
    logic             r_cpu_nxm, w_cpu_nxm;
    logic [WORD-1:0]  r_cpu_rdata, w_cpu_rdata;
    logic             r_dma_ack, w_dma_ack;
    logic             r_dma_nxm, w_dma_nxm;
    logic [WORD-1:0]  r_dma_rdata, w_dma_rdata;

    logic             w_pick;
    logic             w_valid;
    logic             w_hit;
    logic             w_fin;
    logic             w_tmo;
    logic [WORD-1:0]  w_res;

    rr_pick2 u_pick (
        .req   ({dma.req, cpu.req}),
        .last  (r_last),
        .grant (w_pick),
        .valid (w_valid)
    );

    // Sequencer next state and next registered outputs
    always_comb begin
        w_state     = r_state;
        w_owner     = r_owner;
        w_last      = r_last;
        w_write     = r_write;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_cnt       = r_cnt;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_cpu_ack   = 1'b0;
        w_cpu_nxm   = 1'b0;
        w_cpu_rdata = r_cpu_rdata;
        w_dma_ack   = 1'b0;
        w_dma_nxm   = 1'b0;
        w_dma_rdata = r_dma_rdata;
        w_fin       = 1'b0;
        w_tmo       = 1'b0;
        w_hit       = r_write ? write_ack : read_ack;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_owner     = owner_t'(w_pick);
                    w_last      = w_pick;
                    w_write     = w_pick ? dma.write : cpu.write;
                    w_addr      = w_pick ? dma.addr  : cpu.addr;
                    w_wdata     = w_pick ? dma.wdata : cpu.wdata;
                    w_mem_read  = ~w_write;
                    w_mem_write = w_write;
                    w_state     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt   = '0;
                w_state = ST_BUSY;
            end
            ST_BUSY: begin
                if (r_cnt != CNT_MAX) begin
                    w_cnt = r_cnt + 8'd1;
                end
                if (w_hit) begin
                    w_fin   = 1'b1;
                    w_state = ST_DONE;
                end else if (r_cnt >= TO_LAST) begin
                    w_fin   = 1'b1;
                    w_tmo   = 1'b1;
                    w_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
        w_res = w_tmo ? '0 : mem_read_data;
        if (w_fin && r_owner == OWN_CPU) begin
            w_cpu_ack = 1'b1;
            w_cpu_nxm = w_tmo;
            if (w_tmo || !r_write) begin
                w_cpu_rdata = w_res;
            end
        end
        if (w_fin && r_owner == OWN_DMA) begin
            w_dma_ack = 1'b1;
            w_dma_nxm = w_tmo;
            if (w_tmo || !r_write) begin
                w_dma_rdata = w_res;
            end
        end
    end

    // State and output registers; reset aborts any transaction silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_CPU;
            r_last      <= 1'b1;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_nxm   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_ack   <= 1'b0;
            r_dma_nxm   <= 1'b0;
            r_dma_rdata <= '0;
        end else begin
            r_state     <= w_state;
            r_owner     <= w_owner;
            r_last      <= w_last;
            r_write     <= w_write;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_cnt       <= w_cnt;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_cpu_ack   <= w_cpu_ack;
            r_cpu_nxm   <= w_cpu_nxm;
            r_cpu_rdata <= w_cpu_rdata;
            r_dma_ack   <= w_dma_ack;
            r_dma_nxm   <= w_dma_nxm;
            r_dma_rdata <= w_dma_rdata;
        end
    end

    assign mem_addr       = r_addr;
    assign mem_write_data = r_wdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign cpu.ack        = r_cpu_ack;
    assign cpu.nxm        = r_cpu_nxm;
    assign cpu.rdata      = r_cpu_rdata;
    assign dma.ack        = r_dma_ack;
    assign dma.nxm        = r_dma_nxm;
    assign dma.rdata      = r_dma_rdata;

endmodule
